// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between the console (priority) and the AVR loader,
// running each access as setup/strobe/hold with a starvation counter bounding AVR latency.
module sram_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        con_req,
    input  logic        con_we,
    input  logic [20:0] con_addr,
    input  logic [7:0]  con_wdata,
    output logic        con_ack,
    output logic [7:0]  con_rdata,
    input  logic        avr_req,
    input  logic        avr_we,
    input  logic [20:0] avr_addr,
    input  logic [7:0]  avr_wdata,
    output logic        avr_ack,
    output logic [7:0]  avr_rdata,
    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_data_in,
    output logic [7:0]  sram_data_out,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam logic [3:0] WAIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        avr_sel_q, avr_sel_d;
    logic        we_q, we_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  con_rdata_q, con_rdata_d;
    logic [7:0]  avr_rdata_q, avr_rdata_d;
    logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic        data_oe_q, data_oe_d, con_ack_q, con_ack_d, avr_ack_q, avr_ack_d;
    logic        pick_avr, capture;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        avr_sel_d = avr_sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pick_avr  = !con_req || starve_q == LIMIT;
        capture   = state_q == STROBE && cnt_q == 4'd1 && !we_q;
        con_rdata_d = capture && !avr_sel_q ? sram_data_in : con_rdata_q;
        avr_rdata_d = capture && avr_sel_q ? sram_data_in : avr_rdata_q;
        case (state_q)
            IDLE: if (con_req || avr_req) begin
                state_d   = SETUP;
                avr_sel_d = pick_avr;
                we_d      = pick_avr ? avr_we : con_we;
                addr_d    = pick_avr ? avr_addr : con_addr;
                wdata_d   = pick_avr ? avr_wdata : con_wdata;
                starve_d  = pick_avr || !avr_req ? 4'd0 : starve_q == LIMIT ? LIMIT : starve_q + 4'd1;
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = WAIT;
            end
            STROBE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? HOLD : STROBE;
            end
            default: state_d = IDLE;
        endcase
        // Pin values are registered from the next state so they line up with the FSM phase.
        ce_n_d    = state_d == IDLE;
        oe_n_d    = !(state_d == STROBE && !we_d);
        we_n_d    = !(state_d == STROBE && we_d);
        data_oe_d = state_d != IDLE && we_d;
        con_ack_d = state_d == HOLD && !avr_sel_d;
        avr_ack_d = state_d == HOLD && avr_sel_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            starve_q    <= 4'd0;
            avr_sel_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 21'd0;
            wdata_q     <= 8'd0;
            con_rdata_q <= 8'd0;
            avr_rdata_q <= 8'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            con_ack_q   <= 1'b0;
            avr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            avr_sel_q   <= avr_sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            con_rdata_q <= con_rdata_d;
            avr_rdata_q <= avr_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
            con_ack_q   <= con_ack_d;
            avr_ack_q   <= avr_ack_d;
        end
    end

    assign con_ack       = con_ack_q;
    assign avr_ack       = avr_ack_q;
    assign con_rdata     = con_rdata_q;
    assign avr_rdata     = avr_rdata_q;
    assign sram_addr     = addr_q;
    assign sram_data_out = wdata_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random stimulus for sram_arbiter, checked every cycle
// against a transaction-level model (grant decision plus cycle offset within the access).
module tb_sram_arbiter;
    localparam int W  = 2;
    localparam int SL = 4;
    localparam int CB = 3 * (W + 3);
    localparam int AB = 6 * (W + 3);

    logic clk = 1'b0, reset = 1'b1;
    logic con_req = 1'b0, con_we = 1'b0, avr_req = 1'b0, avr_we = 1'b0;
    logic [20:0] con_addr = '0, avr_addr = '0;
    logic [7:0] con_wdata = '0, avr_wdata = '0, sram_data_in = '0;
    logic con_ack, avr_ack, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [7:0] con_rdata, avr_rdata, sram_data_out;
    logic [20:0] sram_addr;

    logic x1_req = 1'b0, x15_req = 1'b0;
    logic x1_cack, x1_aack, x1_doe, x1_ce, x1_oe, x1_we;
    logic x15_cack, x15_aack, x15_doe, x15_ce, x15_oe, x15_we;
    logic [7:0] x1_crd, x1_ard, x1_do, x15_crd, x15_ard, x15_do;
    logic [20:0] x1_a, x15_a;

    int errors = 0, checks = 0;
    bit go = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .con_req(con_req), .con_we(con_we), .con_addr(con_addr), .con_wdata(con_wdata),
        .con_ack(con_ack), .con_rdata(con_rdata),
        .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
        .avr_ack(avr_ack), .avr_rdata(avr_rdata),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
        .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(SL)) u1 (
        .clk(clk), .reset(reset),
        .con_req(x1_req), .con_we(1'b0), .con_addr(21'h0), .con_wdata(8'h0),
        .con_ack(x1_cack), .con_rdata(x1_crd),
        .avr_req(1'b0), .avr_we(1'b0), .avr_addr(21'h0), .avr_wdata(8'h0),
        .avr_ack(x1_aack), .avr_rdata(x1_ard),
        .sram_addr(x1_a), .sram_data_in(8'h3C), .sram_data_out(x1_do),
        .sram_data_oe(x1_doe), .sram_ce_n(x1_ce), .sram_oe_n(x1_oe), .sram_we_n(x1_we)
    );

    sram_arbiter #(.WAIT_CYCLES(15), .STARVE_LIMIT(SL)) u15 (
        .clk(clk), .reset(reset),
        .con_req(x15_req), .con_we(1'b0), .con_addr(21'h0), .con_wdata(8'h0),
        .con_ack(x15_cack), .con_rdata(x15_crd),
        .avr_req(1'b0), .avr_we(1'b0), .avr_addr(21'h0), .avr_wdata(8'h0),
        .avr_ack(x15_aack), .avr_rdata(x15_ard),
        .sram_addr(x15_a), .sram_data_in(8'h3C), .sram_data_out(x15_do),
        .sram_data_oe(x15_doe), .sram_ce_n(x15_ce), .sram_oe_n(x15_oe), .sram_we_n(x15_we)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unwritten SRAM locations read back as a fixed hash of the address.
    function automatic logic [7:0] dflt(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ 8'h96;
    endfunction

    logic [7:0] dmem [logic [20:0]];
    logic [7:0] rmem [logic [20:0]];

    function automatic logic [7:0] dget(input logic [20:0] a);
        return dmem.exists(a) ? dmem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] rget(input logic [20:0] a);
        return rmem.exists(a) ? rmem[a] : dflt(a);
    endfunction

    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_data_oe) dmem[sram_addr] = sram_data_out;

    always @(negedge clk) sram_data_in = dget(sram_addr);

    bit busy = 0, m_we = 0, m_avr = 0;
    int off = 0, starve = 0;
    logic [20:0] m_addr = '0, e_addr = '0;
    logic [7:0] m_wdata = '0, e_dout = '0, rd_con = '0, rd_avr = '0;

    // Model: an access is a grant followed by offsets 0=setup, 1..W=strobe, W+1=hold, W+2=idle.
    always @(posedge clk) begin
        if (busy && m_we && off >= 1 && off <= W) rmem[m_addr] = m_wdata;
        if (reset) begin
            busy = 0; starve = 0; rd_con = '0; rd_avr = '0; e_addr = '0; e_dout = '0;
        end else if (busy) begin
            if (!m_we && off == W) begin
                if (m_avr) rd_avr = rget(m_addr);
                else rd_con = rget(m_addr);
            end
            off++;
            if (off == W + 2) busy = 0;
        end else if (con_req || avr_req) begin
            m_avr = !con_req || starve == SL;
            starve = (m_avr || !avr_req) ? 0 : (starve < SL ? starve + 1 : SL);
            m_we = m_avr ? avr_we : con_we;
            m_addr = m_avr ? avr_addr : con_addr;
            m_wdata = m_avr ? avr_wdata : con_wdata;
            e_addr = m_addr; e_dout = m_wdata;
            busy = 1; off = 0;
        end
    end

    bit st;
    always @(negedge clk) if (go) begin
        st = busy && off >= 1 && off <= W;
        chk("ce_n", 32'(sram_ce_n), 32'(!busy));
        chk("oe_n", 32'(sram_oe_n), 32'(!(st && !m_we)));
        chk("we_n", 32'(sram_we_n), 32'(!(st && m_we)));
        chk("data_oe", 32'(sram_data_oe), 32'(busy && m_we));
        chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        chk("data_out", 32'(sram_data_out), 32'(e_dout));
        chk("con_ack", 32'(con_ack), 32'(busy && off == W + 1 && !m_avr));
        chk("avr_ack", 32'(avr_ack), 32'(busy && off == W + 1 && m_avr));
        chk("con_rdata", 32'(con_rdata), 32'(rd_con));
        chk("avr_rdata", 32'(avr_rdata), 32'(rd_avr));
        chk("strobe_excl", 32'(!sram_oe_n && !sram_we_n), 0);
        chk("drive_on_read", 32'(sram_data_oe && !sram_oe_n), 0);
        chk("ack_excl", 32'(con_ack && avr_ack), 0);
    end

    task automatic rst_pulse();
        con_req = 0; avr_req = 0; reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic rnd_req(output logic we, output logic [20:0] a, output logic [7:0] d);
        we = 1'($urandom_range(0, 1));
        a = 21'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a[20] = 1'b1;
        d = 8'($urandom);
    endtask

    initial begin
        int ce, oe, at, at2, doe, wen, nacks, alat, amax, clat;
        logic aseen, found, bad;
        logic [7:0] rd;
        logic [20:0] a;
        logic [9:0] ord;
        rmem[21'h1ABCD] = 8'h5A;
        dmem[21'h1ABCD] = 8'h5A;
        @(negedge clk);
        go = 1;
        @(negedge clk);
        reset = 0;

        con_we = 0; con_addr = 21'h1ABCD; con_req = 1;
        ce = 0; oe = 0; at = 0; aseen = 0; rd = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (!sram_ce_n) ce++;
            if (!sram_oe_n) oe++;
            if (avr_ack) aseen = 1;
            if (con_ack) begin at = n; rd = con_rdata; con_req = 0; end
        end
        chk("t1_ack_latency", at, 4);
        chk("t1_ce_cycles", ce, 4);
        chk("t1_oe_cycles", oe, 2);
        chk("t1_rdata", 32'(rd), 32'h5A);
        chk("t1_no_avr_ack", 32'(aseen), 0);
        chk("t1_rdata_held", 32'(con_rdata), 32'h5A);

        avr_we = 1; avr_addr = 21'h10; avr_wdata = 8'hC3; avr_req = 1;
        at = 0; doe = 0; wen = 0; a = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (sram_data_oe && !sram_ce_n) doe++;
            if (!sram_we_n) wen++;
            if (!sram_ce_n) a = sram_addr;
            if (avr_ack) begin at = n; avr_req = 0; end
        end
        chk("t2_ack_latency", at, 4);
        chk("t2_data_oe_cycles", doe, 4);
        chk("t2_we_cycles", wen, 2);
        chk("t2_addr", 32'(a), 32'h10);
        chk("t2_mem", 32'(dget(21'h10)), 32'hC3);

        rst_pulse();
        con_we = 0; con_addr = 21'h100; avr_we = 1; avr_addr = 21'h200; avr_wdata = 8'($urandom);
        con_req = 1; avr_req = 1;
        ord = '0; nacks = 0; alat = 0; amax = 0;
        for (int n = 0; n < 100 && nacks < 10; n++) begin
            @(negedge clk);
            alat++;
            if (con_ack) begin ord = {ord[8:0], 1'b0}; nacks++; con_addr = con_addr + 21'd1; end
            if (avr_ack) begin
                ord = {ord[8:0], 1'b1}; nacks++;
                if (alat > amax) amax = alat;
                alat = 0; avr_addr = avr_addr + 21'd1; avr_wdata = 8'($urandom);
            end
        end
        con_req = 0; avr_req = 0;
        chk("t3_ack_count", nacks, 10);
        chk("t3_grant_order", 32'(ord), 32'(10'b0000100001));
        chk("t3_avr_latency_bound", 32'(amax <= 25), 1);

        rst_pulse();
        con_we = 0; con_addr = 21'h33; avr_we = 0; avr_addr = 21'h44;
        con_req = 1; avr_req = 1; at = 0; at2 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (con_ack) begin at = n; con_req = 0; end
            if (avr_ack) begin at2 = n; avr_req = 0; end
        end
        chk("t4_con_first", at, 4);
        chk("t4_avr_next", at2, 9);
        chk("t4_con_rdata", 32'(con_rdata), 32'hA5);
        chk("t4_avr_rdata", 32'(avr_rdata), 32'hD2);

        rst_pulse();
        con_we = 1; con_addr = 21'h55; con_wdata = 8'h77; con_req = 1; found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (!sram_we_n) found = 1;
        end
        chk("t5_reached_strobe", 32'(found), 1);
        reset = 1;
        @(negedge clk);
        chk("t5_ce_n", 32'(sram_ce_n), 1);
        chk("t5_we_n", 32'(sram_we_n), 1);
        chk("t5_oe_n", 32'(sram_oe_n), 1);
        chk("t5_data_oe", 32'(sram_data_oe), 0);
        bad = con_ack;
        @(negedge clk);
        bad = bad | con_ack;
        reset = 0; con_we = 0; con_addr = 21'h1ABCD; at = 0; rd = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (con_ack) begin at = n; rd = con_rdata; con_req = 0; end
        end
        chk("t5_no_ack_in_reset", 32'(bad), 0);
        chk("t5_fresh_latency", at, 4);
        chk("t5_fresh_rdata", 32'(rd), 32'h5A);

        x1_req = 1; x15_req = 1; at = 0; at2 = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (x1_cack) begin at = n; x1_req = 0; end
            if (x15_cack) begin at2 = n; x15_req = 0; end
        end
        chk("w1_latency", at, 3);
        chk("w15_latency", at2, 17);
        chk("w1_rdata", 32'(x1_crd), 32'h3C);
        chk("w15_rdata", 32'(x15_crd), 32'h3C);

        rst_pulse();
        clat = 0; alat = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if (con_req) clat++;
            if (avr_req) alat++;
            if (con_ack) begin
                chk("rand_con_latency", 32'(clat <= CB), 1);
                clat = 0;
                if ($urandom_range(0, 1) == 1) rnd_req(con_we, con_addr, con_wdata);
                else con_req = 0;
            end else if (!con_req && $urandom_range(0, 2) == 0) begin
                rnd_req(con_we, con_addr, con_wdata); con_req = 1; clat = 0;
            end
            if (avr_ack) begin
                chk("rand_avr_latency", 32'(alat <= AB), 1);
                alat = 0;
                if ($urandom_range(0, 1) == 1) rnd_req(avr_we, avr_addr, avr_wdata);
                else avr_req = 0;
            end else if (!avr_req && $urandom_range(0, 2) == 0) begin
                rnd_req(avr_we, avr_addr, avr_wdata); avr_req = 1; alat = 0;
            end
            if (reset) reset = 0;
            else if ($urandom_range(0, 799) == 0) begin reset = 1; clat = 0; alat = 0; end
        end
        chk("rand_con_pending", 32'(clat <= CB), 1);
        chk("rand_avr_pending", 32'(alat <= AB), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM access controller that shares the 2 MB × 8 cartridge SRAM between two requesters: the console bus (real-time, high priority) and the AVR loader port (bulk upload/download, low priority). It owns every SRAM pin, sequences each access through setup/strobe/hold phases, and guarantees bounded AVR latency with a starvation counter. It sits in `system` between the AVR command decoder and the console address decoder on one side and the SRAM pins on the other.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: strobe width in clk cycles (range 1–15).
- `STARVE_LIMIT`, 4: consecutive console grants allowed while an AVR request is pending (range 1–15).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `con_req`  in  1  console access request (level).
- `con_we`  in  1  1 = write, 0 = read.
- `con_addr`  in  21  console byte address.
- `con_wdata`  in  8  console write data.
- `con_ack`  out  1  one-cycle pulse: access complete.
- `con_rdata`  out  8  read data; valid while `con_ack` = 1 and held until the next console read.
- `avr_req`, `avr_we`, `avr_addr[20:0]`, `avr_wdata[7:0]`, `avr_ack`, `avr_rdata[7:0]`: identical semantics, AVR side.
- `sram_addr`  out  21  SRAM address.
- `sram_data_in`  in  8  SRAM data bus input.
- `sram_data_out`  out  8  SRAM data bus drive value.
- `sram_data_oe`  out  1  1 = drive `sram_data_out` onto the bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1  active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: when any request is high, latch the winner's addr/we/wdata and go to SETUP. If none is high, stay in IDLE.
- Arbitration:
  - Console wins by default.
  - AVR wins if the console is not requesting.
  - AVR also wins if `starve_cnt` = `STARVE_LIMIT`.
- `starve_cnt` (4 bits):
  - Increments on each console grant made while `avr_req` = 1.
  - Clears on any AVR grant.
  - Clears on any grant made while `avr_req` = 0.
  - Saturates at `STARVE_LIMIT`.
- SETUP (1 cycle): `sram_addr` = latched address, `ce_n` = 0, `oe_n` = `we_n` = 1. On a write, `sram_data_oe` = 1 and `sram_data_out` = wdata.
- STROBE (`WAIT_CYCLES` cycles, 4-bit down counter): read asserts `oe_n` = 0; write asserts `we_n` = 0. On a read, `sram_data_in` is captured into the granted port's rdata register on the last STROBE cycle.
- HOLD (1 cycle): `oe_n` = `we_n` = 1, `ce_n` = 0, address and write data still driven. The granted port's ack = 1. Next state is IDLE.
- In IDLE: `ce_n` = 1 and `sram_data_oe` = 0. `sram_addr` keeps its last value.
- Request/ack rules:
  - A requester holds req/we/addr/wdata stable until its ack.
  - If req is still high in the cycle after ack, that is a new request.
  - Requests are never dropped.
  - The loser's req stays pending; there is no timeout.
- Invariants:
  - `oe_n` and `we_n` are never both 0.
  - `sram_data_oe` = 1 only during a write, and never while `oe_n` = 0.
  - `con_ack` and `avr_ack` are never both 1.

## Timing
- Reset values:
  - State IDLE.
  - `sram_ce_n` = `sram_oe_n` = `sram_we_n` = 1.
  - `sram_data_oe` = 0, `sram_data_out` = 0, `sram_addr` = 0.
  - Both acks = 0, both rdata = 0, `starve_cnt` = 0.
- Reset mid-access: all strobes go high at the next edge, no ack is issued, and the access is abandoned.
- Latency: req sampled in IDLE at edge N gives ack high during cycle N + `WAIT_CYCLES` + 2 (4 cycles with the default). FSM is back in IDLE at N + `WAIT_CYCLES` + 3.
- Back-to-back throughput: one access per `WAIT_CYCLES` + 3 cycles.
- Simultaneous requests in IDLE: the console is granted unless `starve_cnt` = `STARVE_LIMIT`.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Console read, addr 0x1ABCD, SRAM model returns 0x5A: `ce_n` low for 4 cycles, `oe_n` low for 2, `con_ack` pulses 4 cycles after req, `con_rdata` = 0x5A, `avr_ack` stays 0.
- AVR write, addr 0x000010, data 0xC3: `sram_data_oe` = 1 from SETUP through HOLD, `we_n` low for exactly 2 cycles, `sram_addr` = 0x10, model holds 0xC3 afterward.
- Both requesting continuously (console reads 0x100.., AVR writes 0x200..): grant order is C,C,C,C,A,C,C,C,C,A; AVR latency never exceeds 5 × 5 cycles.
- Simultaneous rising requests with `starve_cnt` = 0: console is served first, AVR next, both acks correct and never overlapping.
- `reset` asserted during STROBE of a write: next cycle strobes = 1, `sram_data_oe` = 0, no ack. After release, a fresh request completes normally.
- `WAIT_CYCLES` = 1 and 15 builds: ack latency = 3 and 17 cycles. The strobe-exclusivity assertion holds throughout a 10 000-cycle random stimulus run.
